// File: rtl/path_comp_buffered.sv
// rtl/path_comp_buffered.sv - NoC input-port path computation: input FIFO, XOR route, held output flit, stats
module path_comp_buffered #(
    parameter int                ADDR_W     = 4,
    parameter int                DATA_W     = 7,
    parameter logic [ADDR_W-1:0] LOCAL_ADDR = '0,
    parameter int                FIFO_DEPTH = 4,
    parameter int                PRIO_MSB   = 0,
    parameter int                CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W+ADDR_W-1:0]  in_flit,
    output logic [ADDR_W:0]           out_valid,
    input  logic [ADDR_W:0]           out_ready,
    output logic [DATA_W+ADDR_W-1:0]  out_flit,
    output logic [CNT_W-1:0]          core_cnt,
    output logic [CNT_W-1:0]          fwd_cnt,
    output logic [CNT_W-1:0]          stall_cnt
);
    localparam int FLIT_W = DATA_W + ADDR_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {S_EMPTY, S_FULL} hold_state_t;

    logic [FLIT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    hold_state_t       state;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              handshake;
    logic [FLIT_W-1:0] head;
    logic [ADDR_W-1:0] diff;
    logic [ADDR_W:0]   sel;

    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);
    assign in_ready   = rst_n && !fifo_full;
    assign push       = in_valid && in_ready;
    assign handshake  = |(out_valid & out_ready);
    // The hold register refills whenever it is free or being emptied this edge.
    assign pop        = !fifo_empty && ((state == S_EMPTY) || handshake);
    assign head       = mem[rd_ptr];
    assign diff       = head[ADDR_W-1:0] ^ LOCAL_ADDR;

    always_comb begin
        sel = '0;
        if (diff == '0) begin
            sel[0] = 1'b1;
        end else if (PRIO_MSB == 0) begin
            for (int i = ADDR_W - 1; i >= 0; i--) begin
                if (diff[i]) begin
                    sel        = '0;
                    sel[i + 1] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < ADDR_W; i++) begin
                if (diff[i]) begin
                    sel        = '0;
                    sel[i + 1] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_flit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_EMPTY;
            out_valid <= '0;
            out_flit  <= '0;
            core_cnt  <= '0;
            fwd_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (!fifo_empty) begin
                        state     <= S_FULL;
                        out_valid <= sel;
                        out_flit  <= head;
                    end
                end
                S_FULL: begin
                    if (handshake) begin
                        if (out_valid[0]) begin
                            if (core_cnt != CNT_MAX) core_cnt <= core_cnt + 1'b1;
                        end else begin
                            if (fwd_cnt != CNT_MAX) fwd_cnt <= fwd_cnt + 1'b1;
                        end
                        if (!fifo_empty) begin
                            out_valid <= sel;
                            out_flit  <= head;
                        end else begin
                            state     <= S_EMPTY;
                            out_valid <= '0;
                        end
                    end else if (stall_cnt != CNT_MAX) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= S_EMPTY;
                    out_valid <= '0;
                end
            endcase
        end
    end
endmodule
